// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main controller: Moore FSM sequencing fetch/decode/execute/memory/writeback.
// Optional J support is enabled with `define MULTICYCLE_JUMP_EN.
module multicycle_control #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       OpCode,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             PCWriteCondNe,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDest,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       State,
    output logic             IllegalOp,
    output logic             Retire,
    output logic [CNT_W-1:0] InstrCount
);

    localparam logic [3:0] FETCH     = 4'd0;
    localparam logic [3:0] DECODE    = 4'd1;
    localparam logic [3:0] MEM_ADDR  = 4'd2;
    localparam logic [3:0] MEM_READ  = 4'd3;
    localparam logic [3:0] MEM_WB    = 4'd4;
    localparam logic [3:0] MEM_WRITE = 4'd5;
    localparam logic [3:0] R_EXEC    = 4'd6;
    localparam logic [3:0] R_WB      = 4'd7;
    localparam logic [3:0] BRANCH    = 4'd8;
    localparam logic [3:0] I_EXEC    = 4'd9;
    localparam logic [3:0] I_WB      = 4'd10;
    localparam logic [3:0] HALT      = 4'd12;
`ifdef MULTICYCLE_JUMP_EN
    localparam logic [3:0] JUMP      = 4'd11;
    localparam logic [5:0] OP_J      = 6'b000010;
`endif

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    logic [3:0] state;
    logic [3:0] nextState;
    logic       retireNext;

    assign State = state;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        case (state)
            FETCH:     if (MemReady) nextState = DECODE;
            DECODE: begin
                case (OpCode)
                    OP_RTYPE:              nextState = R_EXEC;
                    OP_LW, OP_SW:          nextState = MEM_ADDR;
                    OP_ADDI, OP_ANDI,
                    OP_ORI:                nextState = I_EXEC;
                    OP_BEQ, OP_BNE:        nextState = BRANCH;
`ifdef MULTICYCLE_JUMP_EN
                    OP_J:                  nextState = JUMP;
`endif
                    default:               nextState = HALT;
                endcase
            end
            MEM_ADDR: begin
                if (OpCode == OP_LW)      nextState = MEM_READ;
                else if (OpCode == OP_SW) nextState = MEM_WRITE;
                else                      nextState = HALT;
            end
            MEM_READ:  if (MemReady) nextState = MEM_WB;
            MEM_WB:    nextState = FETCH;
            MEM_WRITE: if (MemReady) nextState = FETCH;
            R_EXEC:    nextState = R_WB;
            R_WB:      nextState = FETCH;
            I_EXEC:    nextState = I_WB;
            I_WB:      nextState = FETCH;
            BRANCH:    nextState = FETCH;
`ifdef MULTICYCLE_JUMP_EN
            JUMP:      nextState = FETCH;
`endif
            HALT:      nextState = HALT;
            default:   nextState = HALT;
        endcase
    end

    // Datapath control decode; only FETCH (MemReady) and BRANCH (OpCode) look past the state
    always_comb begin
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        PCWriteCondNe = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        MemtoReg      = 1'b0;
        RegDest       = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ALUOp         = 2'b00;
        PCSource      = 2'b00;
        IllegalOp     = 1'b0;
        case (state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            DECODE:    ALUSrcB = 2'b11;
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEM_WB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            R_WB: begin
                RegDest  = 1'b1;
                RegWrite = 1'b1;
            end
            I_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b11;
            end
            I_WB:      RegWrite = 1'b1;
            BRANCH: begin
                ALUSrcA       = 1'b1;
                ALUOp         = 2'b01;
                PCSource      = 2'b01;
                PCWriteCond   = (OpCode == OP_BEQ);
                PCWriteCondNe = (OpCode == OP_BNE);
            end
`ifdef MULTICYCLE_JUMP_EN
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
`endif
            HALT:      IllegalOp = 1'b1;
            default:   IllegalOp = 1'b0;
        endcase
    end

    // An instruction retires on the edge that leaves its final state
    always_comb begin
        retireNext = 1'b0;
        case (state)
            MEM_WB, R_WB, I_WB, BRANCH: retireNext = 1'b1;
            MEM_WRITE:                  retireNext = MemReady;
`ifdef MULTICYCLE_JUMP_EN
            JUMP:                       retireNext = 1'b1;
`endif
            default:                    retireNext = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Retire     <= 1'b0;
            InstrCount <= '0;
        end else begin
            Retire <= retireNext;
            if (retireNext) begin
                InstrCount <= InstrCount + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control; control outputs are compared as one packed word per state.
module tb_multicycle_control;

    localparam int unsigned CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [5:0]       OpCode = 6'd0;
    logic             MemReady = 1'b1;
    logic             PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite, IRWrite;
    logic             MemtoReg, RegDest, RegWrite, ALUSrcA, IllegalOp, Retire;
    logic [1:0]       ALUSrcB, ALUOp, PCSource;
    logic [3:0]       State;
    logic [CNT_W-1:0] InstrCount;

    int tests = 0;
    int fails = 0;

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .OpCode(OpCode), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCWriteCondNe(PCWriteCondNe),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDest(RegDest), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .State(State),
        .IllegalOp(IllegalOp), .Retire(Retire), .InstrCount(InstrCount)
    );

    always #5 clk = ~clk;

    // {PCWrite,PCWriteCond,PCWriteCondNe,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDest,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,IllegalOp}
    logic [17:0] ctrl;
    assign ctrl = {PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite, IRWrite,
                   MemtoReg, RegDest, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp};

    localparam logic [17:0] C_FETCH  = 18'b1_0_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [17:0] C_FWAIT  = 18'b0_0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [17:0] C_DECODE = 18'b0_0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [17:0] C_MADDR  = 18'b0_0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [17:0] C_MREAD  = 18'b0_0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [17:0] C_MWB    = 18'b0_0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [17:0] C_MWRITE = 18'b0_0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [17:0] C_REXEC  = 18'b0_0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [17:0] C_RWB    = 18'b0_0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [17:0] C_IEXEC  = 18'b0_0_0_0_0_0_0_0_0_0_1_10_11_00_0;
    localparam logic [17:0] C_IWB    = 18'b0_0_0_0_0_0_0_0_0_1_0_00_00_00_0;
    localparam logic [17:0] C_BEQ    = 18'b0_1_0_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [17:0] C_BNE    = 18'b0_0_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [17:0] C_HALT   = 18'b0_0_0_0_0_0_0_0_0_0_0_00_00_00_1;
`ifdef MULTICYCLE_JUMP_EN
    localparam logic [17:0] C_JUMP   = 18'b1_0_0_0_0_0_0_0_0_0_0_00_00_10_0;
`endif

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_BAD  = 6'b111111;
    localparam logic [5:0] OP_J    = 6'b000010;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        MemReady = 1'b1;
        OpCode = OP_R;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        MemReady = 1'b0;
        tick();
        tick();
        tests++;
        if (State !== 4'd0 || InstrCount !== '0 || Retire !== 1'b0 || ctrl !== C_FWAIT) begin
            fails++;
            $display("FAIL reset_wait: state=%0d cnt=%0d retire=%b ctrl=%b, want 0 0 0 %b", State, InstrCount, Retire, ctrl, C_FWAIT);
        end
        MemReady = 1'b1;
        #1;
        tests++;
        if (ctrl !== C_FETCH) begin
            fails++;
            $display("FAIL reset_ready: ctrl=%b want %b", ctrl, C_FETCH);
        end
        MemReady = 1'b0;
        reset = 1'b0;
        tick();
        tests++;
        if (State !== 4'd0 || ctrl !== C_FWAIT) begin
            fails++;
            $display("FAIL fetch_hold: state=%0d ctrl=%b, want 0 %b", State, ctrl, C_FWAIT);
        end
    endtask

    task automatic test_rtype();
        logic [3:0]  es [5];
        logic [17:0] ec [5];
        logic        er [5];
        es = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        ec = '{C_FETCH, C_DECODE, C_REXEC, C_RWB, C_FETCH};
        er = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        OpCode = OP_R;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (State !== es[i] || ctrl !== ec[i] || Retire !== er[i]) begin
                fails++;
                $display("FAIL rtype step%0d: state=%0d ctrl=%b retire=%b, want %0d %b %b", i, State, ctrl, Retire, es[i], ec[i], er[i]);
            end
            if (i < 4) tick();
        end
        tests++;
        if (InstrCount !== 32'd1) begin
            fails++;
            $display("FAIL rtype_count: got %0d want 1", InstrCount);
        end
        tick();
        tests++;
        if (Retire !== 1'b0 || InstrCount !== 32'd1) begin
            fails++;
            $display("FAIL rtype_pulse: retire=%b cnt=%0d, want 0 1", Retire, InstrCount);
        end
    endtask

    task automatic test_lw_wait();
        logic [3:0]  es [8];
        logic [17:0] ec [8];
        logic        er [8];
        logic        mr [8];
        es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
        ec = '{C_FETCH, C_DECODE, C_MADDR, C_MREAD, C_MREAD, C_MREAD, C_MWB, C_FETCH};
        er = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        do_reset();
        OpCode = OP_LW;
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (State !== es[i] || ctrl !== ec[i] || Retire !== er[i]) begin
                fails++;
                $display("FAIL lw step%0d: state=%0d ctrl=%b retire=%b, want %0d %b %b", i, State, ctrl, Retire, es[i], ec[i], er[i]);
            end
            MemReady = mr[i];
            if (i < 7) tick();
        end
        tests++;
        if (InstrCount !== 32'd1) begin
            fails++;
            $display("FAIL lw_count: got %0d want 1", InstrCount);
        end
    endtask

    task automatic test_sw_branch();
        logic [3:0]  es [12];
        logic [17:0] ec [12];
        logic        er [12];
        logic        mr [12];
        logic [5:0]  op [12];
        es = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd8, 4'd0};
        ec = '{C_FETCH, C_DECODE, C_MADDR, C_MWRITE, C_MWRITE, C_FETCH,
               C_DECODE, C_BNE, C_FETCH, C_DECODE, C_BEQ, C_FETCH};
        er = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        op = '{OP_SW, OP_SW, OP_SW, OP_SW, OP_SW, OP_BNE, OP_BNE, OP_BNE, OP_BEQ, OP_BEQ, OP_BEQ, OP_BEQ};
        do_reset();
        OpCode = OP_SW;
        for (int i = 0; i < 12; i++) begin
            tests++;
            if (State !== es[i] || ctrl !== ec[i] || Retire !== er[i]) begin
                fails++;
                $display("FAIL sw_br step%0d: state=%0d ctrl=%b retire=%b, want %0d %b %b", i, State, ctrl, Retire, es[i], ec[i], er[i]);
            end
            MemReady = mr[i];
            OpCode = op[i];
            if (i < 11) tick();
        end
        tests++;
        if (InstrCount !== 32'd3) begin
            fails++;
            $display("FAIL sw_br_count: got %0d want 3", InstrCount);
        end
    endtask

    task automatic test_imm();
        logic [3:0]  es [9];
        logic [17:0] ec [9];
        logic        er [9];
        logic [5:0]  op [9];
        es = '{4'd0, 4'd1, 4'd9, 4'd10, 4'd0, 4'd1, 4'd9, 4'd10, 4'd0};
        ec = '{C_FETCH, C_DECODE, C_IEXEC, C_IWB, C_FETCH, C_DECODE, C_IEXEC, C_IWB, C_FETCH};
        er = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        op = '{OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI, OP_ORI, OP_ORI, OP_ORI, OP_ORI, OP_ORI};
        do_reset();
        OpCode = OP_ADDI;
        for (int i = 0; i < 9; i++) begin
            tests++;
            if (State !== es[i] || ctrl !== ec[i] || Retire !== er[i]) begin
                fails++;
                $display("FAIL imm step%0d: state=%0d ctrl=%b retire=%b, want %0d %b %b", i, State, ctrl, Retire, es[i], ec[i], er[i]);
            end
            OpCode = op[i];
            if (i < 8) tick();
        end
        tests++;
        if (InstrCount !== 32'd2) begin
            fails++;
            $display("FAIL imm_count: got %0d want 2", InstrCount);
        end
    endtask

    task automatic test_halt();
        logic [3:0]  es [7];
        logic [17:0] ec [7];
        logic        er [7];
        logic [5:0]  op [7];
        int          bad;
        es = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd1, 4'd12};
        ec = '{C_FETCH, C_DECODE, C_REXEC, C_RWB, C_FETCH, C_DECODE, C_HALT};
        er = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        op = '{OP_R, OP_R, OP_R, OP_R, OP_BAD, OP_BAD, OP_BAD};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            tests++;
            if (State !== es[i] || ctrl !== ec[i] || Retire !== er[i]) begin
                fails++;
                $display("FAIL halt step%0d: state=%0d ctrl=%b retire=%b, want %0d %b %b", i, State, ctrl, Retire, es[i], ec[i], er[i]);
            end
            OpCode = op[i];
            if (i < 6) tick();
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (State !== 4'd12 || ctrl !== C_HALT || Retire !== 1'b0 || InstrCount !== 32'd1) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL halt_hold: %0d bad cycles, last state=%0d ctrl=%b cnt=%0d, want 12 %b 1", bad, State, ctrl, InstrCount, C_HALT);
        end
        OpCode = OP_R;
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if (State !== 4'd0 || InstrCount !== '0 || IllegalOp !== 1'b0) begin
            fails++;
            $display("FAIL halt_reset: state=%0d cnt=%0d illegal=%b, want 0 0 0", State, InstrCount, IllegalOp);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        OpCode = OP_LW;
        tick();
        tick();
        MemReady = 1'b0;
        tick();
        tests++;
        if (State !== 4'd3 || ctrl !== C_MREAD) begin
            fails++;
            $display("FAIL async_pre: state=%0d ctrl=%b, want 3 %b", State, ctrl, C_MREAD);
        end
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if (State !== 4'd0 || ctrl !== C_FWAIT || Retire !== 1'b0 || InstrCount !== '0) begin
            fails++;
            $display("FAIL async_reset: state=%0d ctrl=%b retire=%b cnt=%0d, want 0 %b 0 0", State, ctrl, Retire, InstrCount, C_FWAIT);
        end
        tick();
        reset = 1'b0;
        MemReady = 1'b1;
        tick();
        tests++;
        if (State !== 4'd1 || Retire !== 1'b0 || InstrCount !== '0) begin
            fails++;
            $display("FAIL async_resume: state=%0d retire=%b cnt=%0d, want 1 0 0", State, Retire, InstrCount);
        end
    endtask

    task automatic test_jump();
        do_reset();
        OpCode = OP_J;
        tick();
        tick();
`ifdef MULTICYCLE_JUMP_EN
        tests++;
        if (State !== 4'd11 || ctrl !== C_JUMP) begin
            fails++;
            $display("FAIL jump_state: state=%0d ctrl=%b, want 11 %b", State, ctrl, C_JUMP);
        end
        tick();
        tests++;
        if (State !== 4'd0 || Retire !== 1'b1 || InstrCount !== 32'd1) begin
            fails++;
            $display("FAIL jump_retire: state=%0d retire=%b cnt=%0d, want 0 1 1", State, Retire, InstrCount);
        end
`else
        tests++;
        if (State !== 4'd12 || ctrl !== C_HALT) begin
            fails++;
            $display("FAIL jump_disabled: state=%0d ctrl=%b, want 12 %b", State, ctrl, C_HALT);
        end
        tick();
        tests++;
        if (State !== 4'd12 || Retire !== 1'b0 || InstrCount !== '0) begin
            fails++;
            $display("FAIL jump_disabled_hold: state=%0d retire=%b cnt=%0d, want 12 0 0", State, Retire, InstrCount);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_sw_branch();
        test_imm();
        test_halt();
        test_async_reset();
        test_jump();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle main controller for the MIPS datapath. A Moore-style FSM splits each instruction into fetch, decode, execute, memory and writeback steps. It drives every datapath enable and mux select from the current state.
- Shares one unified instruction/data memory port, with a ready handshake, between fetch and load/store.
- Keeps a retired-instruction counter.

Parameters:
- CNT_W, 32, width of the retired-instruction counter InstrCount.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- OpCode  in  6  opcode field from the instruction register; stable from DECODE until the next FETCH
- MemReady  in  1  memory has completed the current read/write this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU Zero=1 (BEQ)
- PCWriteCondNe  out  1  PC load if ALU Zero=0 (BNE)
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  register-file write data: 0=ALUOut, 1=MDR
- RegDest  out  1  destination register: 0=rt, 1=rd
- RegWrite  out  1  register-file write enable
- ALUSrcA  out  1  ALU A: 0=PC, 1=register A
- ALUSrcB  out  2  ALU B: 00=register B, 01=4, 10=sign-extended immediate, 11=sign-extended immediate shifted left by 2
- ALUOp  out  2  00=add, 01=sub, 10=use funct, 11=decode immediate operation from OpCode
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
- State  out  4  current state, for debug
- IllegalOp  out  1  high while in HALT
- Retire  out  1  one-cycle pulse when an instruction completes
- InstrCount  out  CNT_W  count of retired instructions

Behaviour:
- Reset (asynchronous):
  - State goes to FETCH and InstrCount to 0.
  - Retire=0.
  - The outputs then take the FETCH decode below, with IRWrite/PCWrite gated by MemReady.
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, I_EXEC=9, I_WB=10, JUMP=11, HALT=12. Codes 13-15 go to HALT.
- Outputs are decoded from State. In BRANCH, outputs also use OpCode. IRWrite/PCWrite in FETCH also depend on MemReady. Any output not listed for a state is 0.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=MemReady.
  - Stays in FETCH while MemReady=0. Goes to DECODE when MemReady=1.
- DECODE:
  - Outputs: ALUSrcB=11, ALUOp=00 (branch target into ALUOut).
  - Next state by OpCode:
    - 000000 → R_EXEC
    - 100011 or 101011 → MEM_ADDR
    - 001000, 001100 or 001101 → I_EXEC
    - 000100 or 000101 → BRANCH
    - anything else → HALT
- MEM_ADDR:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Next state: LW → MEM_READ, SW → MEM_WRITE.
- MEM_READ:
  - Outputs: MemRead=1, IorD=1.
  - Holds until MemReady=1, then goes to MEM_WB.
- MEM_WB:
  - Outputs: MemtoReg=1, RegWrite=1, RegDest=0.
  - Next state: FETCH.
- MEM_WRITE:
  - Outputs: MemWrite=1, IorD=1.
  - Holds until MemReady=1, then goes to FETCH.
- R_EXEC:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - Next state: R_WB.
- R_WB:
  - Outputs: RegDest=1, RegWrite=1.
  - Next state: FETCH.
- I_EXEC:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=11.
  - Next state: I_WB.
- I_WB:
  - Outputs: RegDest=0, MemtoReg=0, RegWrite=1.
  - Next state: FETCH.
- BRANCH:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01.
  - PCWriteCond=1 for BEQ; PCWriteCondNe=1 for BNE.
  - Next state: FETCH.
- HALT:
  - All enables 0, IllegalOp=1.
  - Stays in HALT until reset. Retire is never raised in HALT.
- Retire and InstrCount:
  - Retire is registered. It is 1 in the cycle after leaving MEM_WB, R_WB, I_WB, BRANCH or JUMP, or after leaving MEM_WRITE with MemReady=1.
  - InstrCount increments in that same edge and wraps modulo 2^CNT_W.
- Latency, zero-wait memory:
  - LW: 5 cycles.
  - SW, R-type, immediate: 4 cycles.
  - BEQ/BNE: 3 cycles.
  - Each MemReady=0 cycle adds one cycle.
- Reset mid-instruction: the instruction is abandoned. No retire is counted and no enable is held past the reset.

Optional Feature:
- Macro: MULTICYCLE_JUMP_EN.
- Defined: in DECODE, OpCode 000010 (J) goes to JUMP. JUMP drives PCWrite=1, PCSource=10, then goes to FETCH and retires (3 cycles).
- Undefined: JUMP state logic is absent; OpCode 000010 goes to HALT like any undefined opcode.

Test Plan:
- reset=1 then released, MemReady=1, R-type (000000) → State sequence 0,1,6,7,0. RegDest=1 and RegWrite=1 in state 7. Retire pulse, InstrCount=1.
- LW (100011) with MemReady low for 2 cycles in MEM_READ → state 3 held 3 cycles, MemRead=IorD=1. MEM_WB: MemtoReg=1, RegWrite=1. Total 7 cycles, InstrCount +1.
- SW (101011), then BNE (000101) → MemWrite=1 only in state 5. PCWriteCondNe=1 and PCWriteCond=0 in state 8. InstrCount=2 after both.
- ADDI (001000), then ORI (001101) → ALUOp=11, ALUSrcB=10 in state 9. RegWrite=1 in state 10. 4 cycles each.
- OpCode 111111 in DECODE → State=12, IllegalOp=1 held 20 cycles, InstrCount unchanged; reset returns to FETCH with count 0.
- reset asserted asynchronously mid-MEM_READ → State=0 immediately, MemRead stays high as the FETCH request, no Retire. With MULTICYCLE_JUMP_EN, J (000010) → states 0,1,11,0 with PCSource=10.
